// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that arbitrates N_REQ requesters onto a single UART
// frame generator, latching the winner's byte/config and policing a per-frame timeout.
module uart_tx_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   BaudOut,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [8*N_REQ-1:0]     data_in,
  input  logic [4*N_REQ-1:0]     cfg_in,
  input  logic                   tx_active,
  input  logic                   tx_done,
  output logic                   send,
  output logic [7:0]             data_out,
  output logic [1:0]             parity_type,
  output logic                   stop_bits,
  output logic                   data_length,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  // cfg nibble is {stop_bits, data_length, parity_type[1:0]}; reset selects 8 data bits
  localparam logic [3:0] CFG_RST = 4'b0100;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic [3:0]         cfg_q, cfg_d;
  logic               send_q, send_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               terr_q, terr_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

  // Round-robin search starting just after the previous owner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!win_found && req[IDX_W'((32'(last_q) + k) % N_REQ)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((32'(last_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    data_d  = data_q;
    cfg_d   = cfg_q;
    terr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOAD;
          owner_d = win_idx;
          data_d  = data_in[{win_idx, 3'b000} +: 8];
          cfg_d   = cfg_in[{win_idx, 2'b00} +: 4];
        end
      end
      LOAD:      state_d = START;
      START: begin
        // tx_done seen here belongs to no frame of ours and is dropped
        if (cnt_q == CNT_LAST) begin
          state_d = RELEASE;
          terr_d  = 1'b1;
        end else if (tx_active) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_d = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASE;
          terr_d  = 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        last_d  = owner_q;
      end
      default:   state_d = IDLE;
    endcase

    // Counter restarts on every state entry and only runs in START/WAIT_DONE
    if ((state_d == state_q) && ((state_q == START) || (state_q == WAIT_DONE))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    send_d  = (state_d == START);
    busy_d  = (state_d != IDLE);
    grant_d = (state_d != IDLE)    ? (N_REQ'(1) << owner_d) : '0;
    ack_d   = (state_d == RELEASE) ? (N_REQ'(1) << owner_d) : '0;
  end

  always_ff @(posedge BaudOut or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      cfg_q   <= CFG_RST;
      send_q  <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      cfg_q   <= cfg_d;
      send_q  <= send_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

  assign send        = send_q;
  assign data_out    = data_q;
  assign stop_bits   = cfg_q[3];
  assign data_length = cfg_q[2];
  assign parity_type = cfg_q[1:0];
  assign grant       = grant_q;
  assign ack         = ack_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: table of per-cycle vectors plus hand-written
// sequences for timeout abort and asynchronous reset mid-frame.
module tb_uart_tx_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req8;
  logic [31:0] data_in;
  logic [15:0] cfg_in;
  logic        ta;
  logic        td;

  logic        send, stop_bits, data_length, busy, timeout_err;
  logic [7:0]  data_out;
  logic [1:0]  parity_type;
  logic [3:0]  grant, ack;

  logic        send8, stop_bits8, data_length8, busy8, timeout_err8;
  logic [7:0]  data_out8;
  logic [1:0]  parity_type8;
  logic [3:0]  grant8, ack8;

  int errors = 0;
  int checks = 0;

  uart_tx_sched #(.N_REQ(4), .TIMEOUT(32)) u_dut (
    .BaudOut(clk), .rst(rst), .req(req), .data_in(data_in), .cfg_in(cfg_in),
    .tx_active(ta), .tx_done(td), .send(send), .data_out(data_out),
    .parity_type(parity_type), .stop_bits(stop_bits), .data_length(data_length),
    .grant(grant), .ack(ack), .busy(busy), .timeout_err(timeout_err)
  );

  uart_tx_sched #(.N_REQ(4), .TIMEOUT(8)) u_dut8 (
    .BaudOut(clk), .rst(rst), .req(req8), .data_in(data_in), .cfg_in(cfg_in),
    .tx_active(1'b0), .tx_done(1'b0), .send(send8), .data_out(data_out8),
    .parity_type(parity_type8), .stop_bits(stop_bits8), .data_length(data_length8),
    .grant(grant8), .ack(ack8), .busy(busy8), .timeout_err(timeout_err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [15:0] cfg;
    logic        ta;
    logic        td;
    logic        e_send;
    logic [3:0]  e_grant;
    logic [3:0]  e_ack;
    logic        e_busy;
    logic        e_terr;
    logic [7:0]  e_data;
    logic [3:0]  e_cfg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic [3:0] rq, logic [31:0] d, logic [15:0] c,
                              logic a, logic dn, logic s, logic [3:0] g, logic [3:0] k,
                              logic b, logic t, logic [7:0] ed, logic [3:0] ec);
    vec_t v;
    v.do_rst = r;  v.req = rq;   v.data = d;    v.cfg = c;
    v.ta = a;      v.td = dn;    v.e_send = s;  v.e_grant = g;
    v.e_ack = k;   v.e_busy = b; v.e_terr = t;  v.e_data = ed; v.e_cfg = ec;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] main_out();
    return {send, grant, ack, busy, timeout_err, data_out, stop_bits, data_length, parity_type};
  endfunction

  task automatic do_reset();
    rst = 1'b0; req = '0; req8 = '0; ta = 1'b0; td = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] dvec;
    logic [15:0] cvec;
    logic [31:0] da5;
    logic [3:0]  g;
    logic [7:0]  ed;
    logic [3:0]  ec;
    int          r;
    int          nsend;
    logic        got_ack;

    dvec = 32'h44332211;
    cvec = 16'h3C84;
    da5  = 32'h443322A5;

    rst = 1'b1; req = '0; req8 = '0; data_in = '0; cfg_in = '0; ta = 1'b0; td = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("reset_state", 32'(main_out()), 32'({1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 4'b0100}));
    @(negedge clk);
    rst = 1'b1;

    // single frame, requester 0, tx_active 3 cycles after send, tx_done 10 later
    add(1, 4'b0001, da5, cvec, 0, 0, 0, 4'b0001, 4'b0000, 1, 0, 8'hA5, 4'h4);
    for (int k = 0; k < 3; k++)
      add(0, 4'b0001, da5, cvec, 0, 0, 1, 4'b0001, 4'b0000, 1, 0, 8'hA5, 4'h4);
    for (int k = 0; k < 10; k++)
      add(0, 4'b0001, da5, cvec, 1, 0, 0, 4'b0001, 4'b0000, 1, 0, 8'hA5, 4'h4);
    add(0, 4'b0001, da5, cvec, 0, 1, 0, 4'b0001, 4'b0001, 1, 0, 8'hA5, 4'h4);
    add(0, 4'b0000, da5, cvec, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 8'hA5, 4'h4);

    // all four requesting: grants 0,1,2,3,0 with two-cycle gap after each ack
    for (int i = 0; i < 5; i++) begin
      r  = i % 4;
      g  = 4'b0001 << r;
      ed = dvec[8*r +: 8];
      ec = cvec[4*r +: 4];
      add(i == 0, 4'b1111, dvec, cvec, 0, 0, 0, g, 4'b0000, 1, 0, ed, ec);
      add(0,      4'b1111, dvec, cvec, 0, 0, 1, g, 4'b0000, 1, 0, ed, ec);
      add(0,      4'b1111, dvec, cvec, 1, 0, 0, g, 4'b0000, 1, 0, ed, ec);
      add(0,      4'b1111, dvec, cvec, 0, 1, 0, g, g,       1, 0, ed, ec);
      add(0,      4'b1111, dvec, cvec, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, ed, ec);
    end

    // latched config survives input changes and req drop mid-frame
    add(1, 4'b0010, 32'h00005A00, 16'h0090, 0, 0, 0, 4'b0010, 4'b0000, 1, 0, 8'h5A, 4'h9);
    add(0, 4'b0010, 32'h0000C300, 16'h0060, 0, 0, 1, 4'b0010, 4'b0000, 1, 0, 8'h5A, 4'h9);
    add(0, 4'b0000, 32'h0000C300, 16'h0060, 1, 0, 0, 4'b0010, 4'b0000, 1, 0, 8'h5A, 4'h9);
    add(0, 4'b0000, 32'h0000C300, 16'h0060, 0, 1, 0, 4'b0010, 4'b0010, 1, 0, 8'h5A, 4'h9);
    add(0, 4'b0000, 32'h0000C300, 16'h0060, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 8'h5A, 4'h9);

    // tx_active and tx_done together in START: done is not consumed
    add(1, 4'b0001, dvec, cvec, 0, 0, 0, 4'b0001, 4'b0000, 1, 0, 8'h11, 4'h4);
    add(0, 4'b0001, dvec, cvec, 0, 0, 1, 4'b0001, 4'b0000, 1, 0, 8'h11, 4'h4);
    add(0, 4'b0001, dvec, cvec, 1, 1, 0, 4'b0001, 4'b0000, 1, 0, 8'h11, 4'h4);
    add(0, 4'b0001, dvec, cvec, 1, 0, 0, 4'b0001, 4'b0000, 1, 0, 8'h11, 4'h4);
    add(0, 4'b0001, dvec, cvec, 0, 1, 0, 4'b0001, 4'b0001, 1, 0, 8'h11, 4'h4);
    add(0, 4'b0000, dvec, cvec, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 8'h11, 4'h4);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      req     = vecs[i].req;
      data_in = vecs[i].data;
      cfg_in  = vecs[i].cfg;
      ta      = vecs[i].ta;
      td      = vecs[i].td;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), 32'(main_out()),
          32'({vecs[i].e_send, vecs[i].e_grant, vecs[i].e_ack, vecs[i].e_busy,
               vecs[i].e_terr, vecs[i].e_data, vecs[i].e_cfg}));
    end

    // timeout abort with TIMEOUT=8 and tx_active never asserted
    do_reset();
    req8 = 4'b0100;
    @(posedge clk); #1;
    chk("to_grant", 32'(grant8), 32'h4);
    nsend   = 0;
    got_ack = 1'b0;
    for (int c = 0; c < 20 && !got_ack; c++) begin
      @(posedge clk); #1;
      if (ack8 != 4'b0000) got_ack = 1'b1;
      else if (send8) nsend++;
    end
    chk("to_send_cycles", 32'(nsend), 32'd8);
    chk("to_ack", 32'(ack8), 32'h4);
    chk("to_err", 32'(timeout_err8), 32'h1);
    chk("to_send_low", 32'(send8), 32'h0);
    req8 = 4'b0000;
    @(posedge clk); #1;
    chk("to_busy_after", 32'(busy8), 32'h0);
    chk("to_err_pulse", 32'(timeout_err8), 32'h0);

    // asynchronous reset during WAIT_DONE, then requester 3 wins
    do_reset();
    data_in = dvec; cfg_in = cvec;
    req = 4'b0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ta = 1'b1;
    @(posedge clk); #1;
    chk("rst_pre_wait", 32'({send, grant, busy}), 32'({1'b0, 4'b0010, 1'b1}));
    #2 rst = 1'b0;
    #1;
    chk("rst_async", 32'({send, grant, ack, busy, data_out, data_length}),
        32'({1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b1}));
    @(posedge clk); #1;
    chk("rst_no_ack", 32'({ack, grant}), 32'h0);
    @(negedge clk);
    rst = 1'b1; ta = 1'b0; req = 4'b1000;
    @(posedge clk); #1;
    chk("rst_regrant", 32'({grant, data_out, stop_bits, data_length, parity_type}),
        32'({4'b1000, 8'h44, 4'h3}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
